// File: rtl/score_counter.sv
// Snake game score tracker: counts apple edges during play, keeps a binary
// and two-digit BCD score, and raises FINISHED at the winning score.
module score_counter #(
    parameter int TARGET = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] STATE,
    input  logic       APPLE_EATEN,
    output logic [6:0] SCORE_BIN,
    output logic [3:0] SCORE_ONES,
    output logic [3:0] SCORE_TENS,
    output logic       SCORE_PULSE,
    output logic       FINISHED
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [6:0] MAX_SCORE = 7'd99;
    localparam logic [6:0] TARGET_L = 7'(TARGET);

    logic       apple_q, apple_d;
    logic [6:0] score_q, score_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       pulse_q, pulse_d;
    logic       finished_q, finished_d;

    logic       rise;
    logic       inc;
    logic       is_idle;
    logic       is_play;
    logic [6:0] score_inc;
    logic [3:0] ones_inc;
    logic [3:0] tens_inc;

    assign is_idle = (STATE == ST_IDLE);
    assign is_play = (STATE == ST_PLAY);

    // Edge detector runs in every state so a level held across play entry
    // must fall and rise again before it counts.
    assign rise = APPLE_EATEN & ~apple_q;
    assign inc  = rise & is_play & ~finished_q & (score_q < MAX_SCORE);

    assign score_inc = score_q + 7'd1;

    always_comb begin
        ones_inc = ones_q + 4'd1;
        tens_inc = tens_q;
        if (ones_q == 4'd9) begin
            ones_inc = 4'd0;
            tens_inc = tens_q + 4'd1;
        end
    end

    always_comb begin
        apple_d    = APPLE_EATEN;
        score_d    = score_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        pulse_d    = 1'b0;
        finished_d = finished_q;
        unique case (1'b1)
            is_idle: begin
                score_d    = 7'd0;
                ones_d     = 4'd0;
                tens_d     = 4'd0;
                finished_d = 1'b0;
            end
            inc: begin
                score_d    = score_inc;
                ones_d     = ones_inc;
                tens_d     = tens_inc;
                pulse_d    = 1'b1;
                // Set from the next value so it lands with the winning point.
                finished_d = finished_q | (score_inc == TARGET_L);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            apple_q    <= 1'b0;
            score_q    <= 7'd0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            pulse_q    <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            apple_q    <= apple_d;
            score_q    <= score_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            pulse_q    <= pulse_d;
            finished_q <= finished_d;
        end
    end

    assign SCORE_BIN   = score_q;
    assign SCORE_ONES  = ones_q;
    assign SCORE_TENS  = tens_q;
    assign SCORE_PULSE = pulse_q;
    assign FINISHED    = finished_q;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: two instances (TARGET 10 and 99) share stimulus;
// each accepted apple pushes its expected score, popped on SCORE_PULSE.
module tb_score_counter;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    logic       apple;

    logic [6:0] bin10, bin99;
    logic [3:0] ones10, ones99;
    logic [3:0] tens10, tens99;
    logic       pulse10, pulse99;
    logic       fin10, fin99;

    int checks;
    int errors;

    int q10[$];
    int q99[$];
    int m10, m99;
    bit mf10, mf99;

    score_counter #(.TARGET(10)) u10 (
        .CLK(clk), .RESET(rst_n), .STATE(state), .APPLE_EATEN(apple),
        .SCORE_BIN(bin10), .SCORE_ONES(ones10), .SCORE_TENS(tens10),
        .SCORE_PULSE(pulse10), .FINISHED(fin10)
    );

    score_counter #(.TARGET(99)) u99 (
        .CLK(clk), .RESET(rst_n), .STATE(state), .APPLE_EATEN(apple),
        .SCORE_BIN(bin99), .SCORE_ONES(ones99), .SCORE_TENS(tens99),
        .SCORE_PULSE(pulse99), .FINISHED(fin99)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pulse10 === 1'b1) begin
                checks++;
                if (q10.size() == 0) begin
                    errors++;
                    $display("FAIL pulse10_unexpected got bin=%0d want no pulse", bin10);
                end else begin
                    int e;
                    e = q10.pop_front();
                    if (bin10 !== 7'(e) || ones10 !== 4'(e % 10) || tens10 !== 4'(e / 10)) begin
                        errors++;
                        $display("FAIL score10 got %0d/%0d%0d want %0d", bin10, tens10, ones10, e);
                    end
                end
            end
            if (pulse99 === 1'b1) begin
                checks++;
                if (q99.size() == 0) begin
                    errors++;
                    $display("FAIL pulse99_unexpected got bin=%0d want no pulse", bin99);
                end else begin
                    int e;
                    e = q99.pop_front();
                    if (bin99 !== 7'(e) || ones99 !== 4'(e % 10) || tens99 !== 4'(e / 10)) begin
                        errors++;
                        $display("FAIL score99 got %0d/%0d%0d want %0d", bin99, tens99, ones99, e);
                    end
                end
            end
        end
    end

    // Expected effect of one rising apple seen at the next edge.
    task automatic expect_rise();
        if (state == 2'b01) begin
            if (!mf10 && m10 < 99) begin
                m10++;
                q10.push_back(m10);
                if (m10 == 10) mf10 = 1'b1;
            end
            if (!mf99 && m99 < 99) begin
                m99++;
                q99.push_back(m99);
                if (m99 == 99) mf99 = 1'b1;
            end
        end
    endtask

    task automatic apple_pulse(input int gap);
        @(posedge clk); #1;
        apple = 1'b1;
        expect_rise();
        @(posedge clk); #1;
        apple = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_state(input logic [1:0] s);
        @(posedge clk); #1;
        state = s;
    endtask

    task automatic go_idle();
        set_state(2'b00);
        @(posedge clk); #1;
        m10 = 0; m99 = 0; mf10 = 1'b0; mf99 = 1'b0;
    endtask

    task automatic check_outputs(input string name, input int e10, input bit f10,
                                 input int e99, input bit f99);
        checks++;
        if (bin10 !== 7'(e10) || ones10 !== 4'(e10 % 10) || tens10 !== 4'(e10 / 10)
            || fin10 !== f10) begin
            errors++;
            $display("FAIL %s_t10 got bin=%0d tens=%0d ones=%0d fin=%b want %0d fin=%b",
                     name, bin10, tens10, ones10, fin10, e10, f10);
        end
        checks++;
        if (bin99 !== 7'(e99) || ones99 !== 4'(e99 % 10) || tens99 !== 4'(e99 / 10)
            || fin99 !== f99) begin
            errors++;
            $display("FAIL %s_t99 got bin=%0d tens=%0d ones=%0d fin=%b want %0d fin=%b",
                     name, bin99, tens99, ones99, fin99, e99, f99);
        end
    endtask

    task automatic drain(input string name);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q10.size() != 0 || q99.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_pulses got pending %0d/%0d want 0/0",
                     name, q10.size(), q99.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        state = 2'b00;
        apple = 1'b0;
        m10 = 0; m99 = 0; mf10 = 1'b0; mf99 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 1'b0, 0, 1'b0);
        checks++;
        if (pulse10 !== 1'b0 || pulse99 !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse got %b%b want 00", pulse10, pulse99);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs("reset_release", 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_basic_count();
        set_state(2'b01);
        for (int i = 0; i < 5; i++) apple_pulse(2);
        drain("basic");
        check_outputs("basic5", 5, 1'b0, 5, 1'b0);
        @(posedge clk); #1;
        apple = 1'b1;
        expect_rise();
        repeat (20) @(posedge clk);
        #1;
        apple = 1'b0;
        drain("held");
        check_outputs("held_once", 6, 1'b0, 6, 1'b0);
    endtask

    task automatic test_reset_mid();
        go_idle();
        set_state(2'b01);
        for (int i = 0; i < 7; i++) apple_pulse(1);
        drain("mid");
        check_outputs("mid7", 7, 1'b0, 7, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_clear", 0, 1'b0, 0, 1'b0);
        m10 = 0; m99 = 0;
        q10.delete(); q99.delete();
        @(posedge clk); #1;
        state = 2'b00;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs("post_release", 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_carry_finish();
        go_idle();
        set_state(2'b01);
        for (int i = 0; i < 9; i++) apple_pulse(1);
        drain("nine");
        check_outputs("nine", 9, 1'b0, 9, 1'b0);
        apple_pulse(0);
        check_outputs("carry_fin", 10, 1'b1, 10, 1'b0);
        drain("carry");
    endtask

    task automatic test_post_finish();
        for (int i = 0; i < 3; i++) apple_pulse(1);
        drain("post_play");
        check_outputs("post_play", 10, 1'b1, 13, 1'b0);
        set_state(2'b10);
        for (int i = 0; i < 3; i++) apple_pulse(1);
        drain("post_win");
        check_outputs("post_win", 10, 1'b1, 13, 1'b0);
        set_state(2'b00);
        @(posedge clk); #1;
        m10 = 0; m99 = 0; mf10 = 1'b0; mf99 = 1'b0;
        check_outputs("idle_clear", 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_entry_level_high();
        @(posedge clk); #1;
        apple = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        state = 2'b01;
        repeat (4) @(posedge clk);
        #1;
        check_outputs("entry_high", 0, 1'b0, 0, 1'b0);
        apple = 1'b0;
        @(posedge clk); #1;
        apple = 1'b1;
        expect_rise();
        @(posedge clk); #1;
        apple = 1'b0;
        drain("entry");
        check_outputs("entry_rerise", 1, 1'b0, 1, 1'b0);
    endtask

    task automatic test_sweep99();
        go_idle();
        set_state(2'b01);
        for (int i = 0; i < 99; i++) apple_pulse(1);
        drain("sweep");
        check_outputs("sweep99", 10, 1'b1, 99, 1'b1);
        apple_pulse(1);
        drain("sat");
        check_outputs("sat100", 10, 1'b1, 99, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_count();
        test_reset_mid();
        test_carry_finish();
        test_post_finish();
        test_entry_level_high();
        test_sweep99();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
